branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 soc_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 br_valid  in  1  decode presents a branch request.
REQ-004 br_ready  out  1  resolver can accept a request.
REQ-005 br_op  in  5  branch code: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU.
REQ-006 br_pc, br_imm, br_rs1, br_rs2  in  32 each  branch PC, sign-extended B-immediate, source operands.
REQ-007 br_flush  in  1  abort any in-flight request.
REQ-008 cmp_dat_ready  out  1  operand-valid strobe to the comparator.
REQ-009 cmp_op  out  5  comparator op code, same encoding as br_op.
REQ-010 cmp_dat1, cmp_dat2  out  32 each  comparator operands.
REQ-011 cmp_con_met  in  1  registered comparator result, valid one cycle after a cmp_dat_ready edge.
REQ-012 res_valid  out  1  resolution result available.
REQ-013 res_ready  in  1  consumer accepts result.
REQ-014 res_taken  out  1  branch taken.
REQ-015 res_target  out  32  next PC.
REQ-016 res_illegal  out  1  br_op outside 0..5.
REQ-017 res_misalign  out  1  taken target not word aligned (see Configuration).

Function
REQ-018 FSM states IDLE, ISSUE, CAPTURE, RESP. Reset state is IDLE.
REQ-019 br_ready SHALL be 1 only in IDLE with reset low. Acceptance occurs on br_valid&&br_ready at a rising edge, which latches br_op, br_pc, br_imm, br_rs1 and br_rs2.
REQ-020 On acceptance with br_op<=5, IDLE->ISSUE. With br_op>5, IDLE->RESP and the result is taken=0, target=pc+4, illegal=1, with no comparator issue.
REQ-021 In ISSUE only, cmp_dat_ready=1 and cmp_op/cmp_dat1/cmp_dat2 carry the latched op/rs1/rs2. In all other states cmp_dat_ready=0. ISSUE->CAPTURE unconditionally.
REQ-022 In CAPTURE, cmp_con_met is sampled at the rising edge and stored into res_taken. res_target becomes pc+imm if taken, otherwise pc+4. CAPTURE->RESP.
REQ-023 Target arithmetic SHALL be 32-bit modulo 2^32; wrap-around is silent (0xFFFFFFFC+4 = 0x00000000).
REQ-024 In RESP, res_valid=1 and all res_* outputs hold stable until res_ready=1 at an edge, then RESP->IDLE.
REQ-025 Latency from acceptance edge to res_valid high: 3 edges for legal ops, 1 edge for illegal ops. Throughput: at most one request per 4 cycles.
REQ-026 br_flush=1 at an edge forces IDLE from any state, drops res_valid, and clears res_* to 0. Flush wins over a simultaneous acceptance, which does not occur, and over res_ready.
REQ-027 res_* outputs SHALL be 0 whenever res_valid=0.

Reset
REQ-028 Reset assertion SHALL immediately, without a clock, force IDLE and clear all outputs and latched operands to 0.
REQ-029 While reset is high, br_ready=0 and no request is accepted. A request in flight at reset is discarded.
REQ-030 Operation SHALL resume on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro BRANCH_MISALIGN_CHK_EN.
- Defined: res_misalign is set in CAPTURE when res_taken=1 and res_target[1:0]!=0, and is held in RESP.
- Undefined: res_misalign is tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-032 BEQ with rs1=rs2=0x12345678, pc=0x100, imm=0x20 -> res_valid 3 edges after acceptance, taken=1, target=0x120.
REQ-033 BLTU vs BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x200 -> BLTU: taken=0, target=0x204. BLT: taken=1, target=0x200+imm.
REQ-034 br_op=7, pc=0xFFFFFFFC -> res_valid 1 edge after acceptance, illegal=1, taken=0, target=0x00000000, and cmp_dat_ready never asserts.
REQ-035 res_ready held 0 for 5 cycles in RESP -> outputs stable, br_ready=0 throughout. res_ready=1 -> IDLE next edge.
REQ-036 br_flush asserted in CAPTURE, and separately reset pulsed between clock edges in ISSUE -> IDLE immediately, res_valid never asserts, all outputs 0.
REQ-037 With BRANCH_MISALIGN_CHK_EN defined: BNE taken, pc=0x100, imm=0x6 -> target=0x106, misalign=1. Same stimulus with the macro undefined -> misalign=0.

Source files
------------

// File: rtl/branch_resolver.sv
// Conditional-branch resolver: issues operands to an external registered comparator and returns taken/target.
// Optional taken-target alignment check enabled by BRANCH_MISALIGN_CHK_EN.
module branch_resolver (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [4:0]  br_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] br_rs1,
    input  logic [31:0] br_rs2,
    input  logic        br_flush,
    output logic        cmp_dat_ready,
    output logic [4:0]  cmp_op,
    output logic [31:0] cmp_dat1,
    output logic [31:0] cmp_dat2,
    input  logic        cmp_con_met,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_taken,
    output logic [31:0] res_target,
    output logic        res_illegal,
    output logic        res_misalign
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } br_req_t;

    state_t      state_q;
    br_req_t     req_q;
    logic [31:0] tgt_taken;
    logic [31:0] tgt_seq;

    assign tgt_taken = req_q.pc + req_q.imm;
    assign tgt_seq   = req_q.pc + 32'd4;

    // Reset gates br_ready directly so no request slips in while reset is held.
    assign br_ready      = (state_q == IDLE) && !reset;
    assign cmp_dat_ready = (state_q == ISSUE);
    assign cmp_op        = cmp_dat_ready ? req_q.op  : 5'd0;
    assign cmp_dat1      = cmp_dat_ready ? req_q.rs1 : 32'd0;
    assign cmp_dat2      = cmp_dat_ready ? req_q.rs2 : 32'd0;

`ifdef BRANCH_MISALIGN_CHK_EN
    logic misalign_q;
    assign res_misalign = misalign_q;
`else
    assign res_misalign = 1'b0;
`endif

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_target  <= 32'd0;
            res_illegal <= 1'b0;
`ifdef BRANCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else if (br_flush) begin
            state_q     <= IDLE;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_target  <= 32'd0;
            res_illegal <= 1'b0;
`ifdef BRANCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (br_valid) begin
                        req_q <= '{op: br_op, pc: br_pc, imm: br_imm, rs1: br_rs1, rs2: br_rs2};
                        if (br_op > 5'd5) begin
                            // Unknown op: answer immediately, comparator untouched.
                            state_q     <= RESP;
                            res_valid   <= 1'b1;
                            res_taken   <= 1'b0;
                            res_target  <= br_pc + 32'd4;
                            res_illegal <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: state_q <= CAPTURE;
                CAPTURE: begin
                    state_q     <= RESP;
                    res_valid   <= 1'b1;
                    res_taken   <= cmp_con_met;
                    res_target  <= cmp_con_met ? tgt_taken : tgt_seq;
                    res_illegal <= 1'b0;
`ifdef BRANCH_MISALIGN_CHK_EN
                    misalign_q  <= cmp_con_met && (tgt_taken[1:0] != 2'b00);
`endif
                end
                RESP: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid   <= 1'b0;
                        res_taken   <= 1'b0;
                        res_target  <= 32'd0;
                        res_illegal <= 1'b0;
`ifdef BRANCH_MISALIGN_CHK_EN
                        misalign_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a behavioural registered comparator.
module tb_branch_resolver;

    logic        soc_clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [4:0]  br_op = '0;
    logic [31:0] br_pc = '0, br_imm = '0, br_rs1 = '0, br_rs2 = '0;
    logic        br_flush = 1'b0;
    logic        cmp_dat_ready;
    logic [4:0]  cmp_op;
    logic [31:0] cmp_dat1, cmp_dat2;
    logic        cmp_con_met = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_illegal;
    logic        res_misalign;

    int n_checks = 0;
    int n_fail = 0;
    int cmp_seen = 0;
    int rv_seen = 0;

`ifdef BRANCH_MISALIGN_CHK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    branch_resolver dut (
        .soc_clk(soc_clk), .reset(reset),
        .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .br_flush(br_flush),
        .cmp_dat_ready(cmp_dat_ready), .cmp_op(cmp_op), .cmp_dat1(cmp_dat1), .cmp_dat2(cmp_dat2),
        .cmp_con_met(cmp_con_met),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .res_illegal(res_illegal), .res_misalign(res_misalign)
    );

    always #5 soc_clk = ~soc_clk;

    // Registered comparator: result appears the cycle after the operand strobe.
    always @(posedge soc_clk) begin
        if (cmp_dat_ready) begin
            case (cmp_op)
                5'd0: cmp_con_met <= (cmp_dat1 == cmp_dat2);
                5'd1: cmp_con_met <= (cmp_dat1 != cmp_dat2);
                5'd2: cmp_con_met <= ($signed(cmp_dat1) <  $signed(cmp_dat2));
                5'd3: cmp_con_met <= ($signed(cmp_dat1) >= $signed(cmp_dat2));
                5'd4: cmp_con_met <= (cmp_dat1 <  cmp_dat2);
                5'd5: cmp_con_met <= (cmp_dat1 >= cmp_dat2);
                default: cmp_con_met <= 1'b0;
            endcase
        end
    end

    always @(negedge soc_clk) begin
        if (cmp_dat_ready) cmp_seen <= cmp_seen + 1;
        if (res_valid) rv_seen <= rv_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Waits (bounded) for br_ready, then presents one request for one edge.
    task automatic send(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        int w = 0;
        while (!br_ready && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (br_ready !== 1'b1) begin
            $display("FAIL send_ready: br_ready=%b required 1", br_ready);
            n_fail++;
        end
        br_valid = 1'b1; br_op = op; br_pc = pc; br_imm = imm; br_rs1 = rs1; br_rs2 = rs2;
        tick();
        br_valid = 1'b0;
    endtask

    // Latency counted with the acceptance edge as edge 1.
    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({br_ready, cmp_dat_ready, res_valid, res_taken, res_illegal, res_misalign} !== 6'b0 ||
            res_target !== 32'd0 || cmp_dat1 !== 32'd0 || cmp_op !== 5'd0) begin
            $display("FAIL reset_outputs: rdy=%b cmp=%b rv=%b tgt=%h required all 0",
                     br_ready, cmp_dat_ready, res_valid, res_target);
            n_fail++;
        end
        #9 reset = 1'b0;
        tick();
        n_checks++;
        if (br_ready !== 1'b1) begin
            $display("FAIL reset_resume: br_ready=%b required 1", br_ready);
            n_fail++;
        end
    endtask

    task automatic test_beq();
        int lat;
        send(5'd0, 32'h100, 32'h20, 32'h12345678, 32'h12345678);
        n_checks++;
        if (cmp_dat_ready !== 1'b1 || cmp_op !== 5'd0 || cmp_dat1 !== 32'h12345678 || cmp_dat2 !== 32'h12345678) begin
            $display("FAIL beq_issue: rdy=%b op=%0d d1=%h d2=%h required 1 0 12345678 12345678",
                     cmp_dat_ready, cmp_op, cmp_dat1, cmp_dat2);
            n_fail++;
        end
        wait_res(lat);
        n_checks++;
        if (lat != 3 || res_taken !== 1'b1 || res_target !== 32'h120 || res_illegal !== 1'b0) begin
            $display("FAIL beq_result: lat=%0d taken=%b tgt=%h ill=%b required 3 1 00000120 0",
                     lat, res_taken, res_target, res_illegal);
            n_fail++;
        end
        release_res();
        n_checks++;
        if (res_valid !== 1'b0 || res_target !== 32'd0 || br_ready !== 1'b1) begin
            $display("FAIL beq_release: rv=%b tgt=%h rdy=%b required 0 0 1", res_valid, res_target, br_ready);
            n_fail++;
        end
    endtask

    task automatic test_bltu_blt();
        int lat;
        send(5'd4, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1);
        wait_res(lat);
        n_checks++;
        if (lat != 3 || res_taken !== 1'b0 || res_target !== 32'h204) begin
            $display("FAIL bltu_result: lat=%0d taken=%b tgt=%h required 3 0 00000204", lat, res_taken, res_target);
            n_fail++;
        end
        release_res();
        send(5'd2, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1);
        wait_res(lat);
        n_checks++;
        if (lat != 3 || res_taken !== 1'b1 || res_target !== 32'h240) begin
            $display("FAIL blt_result: lat=%0d taken=%b tgt=%h required 3 1 00000240", lat, res_taken, res_target);
            n_fail++;
        end
        release_res();
    endtask

    task automatic test_illegal();
        int lat;
        int c0;
        c0 = cmp_seen;
        send(5'd7, 32'hFFFFFFFC, 32'h10, 32'h0, 32'h0);
        wait_res(lat);
        n_checks++;
        if (lat != 1 || res_illegal !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'h0) begin
            $display("FAIL illegal_result: lat=%0d ill=%b taken=%b tgt=%h required 1 1 0 00000000",
                     lat, res_illegal, res_taken, res_target);
            n_fail++;
        end
        release_res();
        tick();
        n_checks++;
        if (cmp_seen != c0) begin
            $display("FAIL illegal_no_issue: cmp strobes=%0d required 0", cmp_seen - c0);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send(5'd1, 32'h400, 32'h10, 32'h1, 32'h2);
        wait_res(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== 32'h410 || br_ready !== 1'b0) begin
                $display("FAIL hold_cycle%0d: rv=%b taken=%b tgt=%h rdy=%b required 1 1 00000410 0",
                         i, res_valid, res_taken, res_target, br_ready);
                n_fail++;
            end
        end
        release_res();
        n_checks++;
        if (res_valid !== 1'b0 || br_ready !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'd0) begin
            $display("FAIL hold_release: rv=%b rdy=%b taken=%b tgt=%h required 0 1 0 0",
                     res_valid, br_ready, res_taken, res_target);
            n_fail++;
        end
    endtask

    task automatic test_flush_capture();
        int rv0;
        rv0 = rv_seen;
        send(5'd0, 32'h500, 32'h8, 32'h7, 32'h7);
        tick();
        br_flush = 1'b1;
        tick();
        br_flush = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || br_ready !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'd0 || cmp_dat_ready !== 1'b0) begin
            $display("FAIL flush_state: rv=%b rdy=%b taken=%b tgt=%h cmp=%b required 0 1 0 0 0",
                     res_valid, br_ready, res_taken, res_target, cmp_dat_ready);
            n_fail++;
        end
        repeat (4) tick();
        n_checks++;
        if (rv_seen != rv0) begin
            $display("FAIL flush_no_result: res_valid cycles=%0d required 0", rv_seen - rv0);
            n_fail++;
        end
    endtask

    task automatic test_reset_issue();
        int rv0;
        rv0 = rv_seen;
        send(5'd1, 32'h600, 32'h8, 32'h1, 32'h2);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (cmp_dat_ready !== 1'b0 || br_ready !== 1'b0 || cmp_dat1 !== 32'd0 || res_valid !== 1'b0) begin
            $display("FAIL reset_async: cmp=%b rdy=%b d1=%h rv=%b required 0 0 0 0",
                     cmp_dat_ready, br_ready, cmp_dat1, res_valid);
            n_fail++;
        end
        #1 reset = 1'b0;
        tick();
        n_checks++;
        if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
            $display("FAIL reset_idle: rdy=%b rv=%b required 1 0", br_ready, res_valid);
            n_fail++;
        end
        repeat (4) tick();
        n_checks++;
        if (rv_seen != rv0) begin
            $display("FAIL reset_no_result: res_valid cycles=%0d required 0", rv_seen - rv0);
            n_fail++;
        end
    endtask

    task automatic test_misalign();
        int lat;
        send(5'd1, 32'h100, 32'h6, 32'h1, 32'h0);
        wait_res(lat);
        n_checks++;
        if (res_taken !== 1'b1 || res_target !== 32'h106 || res_misalign !== EXP_MIS) begin
            $display("FAIL misalign_result: taken=%b tgt=%h mis=%b required 1 00000106 %b",
                     res_taken, res_target, res_misalign, EXP_MIS);
            n_fail++;
        end
        release_res();
        n_checks++;
        if (res_misalign !== 1'b0) begin
            $display("FAIL misalign_clear: mis=%b required 0", res_misalign);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        res_ready = 1'b1;
        send(5'd3, 32'h1000, 32'hFFFFFFF0, 32'h5, 32'h5);
        wait_res(lat);
        n_checks++;
        if (lat != 3 || res_taken !== 1'b1 || res_target !== 32'h00000FF0) begin
            $display("FAIL b2b_bge: lat=%0d taken=%b tgt=%h required 3 1 00000ff0", lat, res_taken, res_target);
            n_fail++;
        end
        tick();
        n_checks++;
        if (br_ready !== 1'b1) begin
            $display("FAIL b2b_ready: br_ready=%b required 1", br_ready);
            n_fail++;
        end
        send(5'd5, 32'h300, 32'h80, 32'h1, 32'hFFFFFFFF);
        wait_res(lat);
        n_checks++;
        if (lat != 3 || res_taken !== 1'b0 || res_target !== 32'h304) begin
            $display("FAIL b2b_bgeu: lat=%0d taken=%b tgt=%h required 3 0 00000304", lat, res_taken, res_target);
            n_fail++;
        end
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_bltu_blt();
        test_illegal();
        test_backpressure();
        test_flush_capture();
        test_reset_issue();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
